// File: rtl/sonda_pkg.sv
// Shared types and width helpers for the debug-probe capture sequencer.
package sonda_pkg;

    localparam int ESTADO_W  = 3;
    localparam int PROF_DEF  = 64;
    localparam int DIR_W_DEF = $clog2(PROF_DEF);

    typedef enum logic [ESTADO_W-1:0] {
        ST_REPOSO  = 3'd0,
        ST_PRE     = 3'd1,
        ST_ESPERA  = 3'd2,
        ST_POST    = 3'd3,
        ST_LISTO   = 3'd4,
        ST_LECTURA = 3'd5
    } estado_t;

    function automatic int ancho_dir(input int prof);
        return (prof < 2) ? 1 : $clog2(prof);
    endfunction

endpackage

// File: rtl/sonda_captura_if.sv
// Readout stream of the capture sequencer: valid/ready with a last-sample flag.
interface sonda_captura_if #(
    parameter int ANCHO = 17
) ();

    logic [ANCHO-1:0] dato;
    logic             dato_valido;
    logic             dato_listo;
    logic             dato_ultimo;

    modport master (
        output dato,
        output dato_valido,
        output dato_ultimo,
        input  dato_listo
    );

    modport slave (
        input  dato,
        input  dato_valido,
        input  dato_ultimo,
        output dato_listo
    );

endinterface

// File: rtl/sonda_mem.sv
// Simple dual-port sample buffer; registered read with enable so it maps onto block RAM.
module sonda_mem
    import sonda_pkg::*;
#(
    parameter int ANCHO = 17,
    parameter int PROF  = 64,
    parameter int AW    = ancho_dir(PROF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    dir_esc,
    input  logic [ANCHO-1:0] dato_esc,
    input  logic             re,
    input  logic [AW-1:0]    dir_lec,
    output logic [ANCHO-1:0] dato_lec
);

    logic [ANCHO-1:0] ram [PROF];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[dir_esc] <= dato_esc;
        end
    end

    // Output register resets so the readout port starts at zero; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            dato_lec <= '0;
        end else if (re) begin
            dato_lec <= ram[dir_lec];
        end
    end

endmodule

// File: rtl/sonda_captura.sv
// Capture sequencer: records the probe bus into a ring around a masked trigger,
// then streams the frozen window out oldest-first.
module sonda_captura
    import sonda_pkg::*;
#(
    parameter int ANCHO = 17,
    parameter int PROF  = 64,
    parameter int POST  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ANCHO-1:0]    sonda,
    input  logic [ANCHO-1:0]    patron,
    input  logic [ANCHO-1:0]    mascara,
    input  logic                armar,
    input  logic                abortar,
    sonda_captura_if.master     lectura,
    output logic                disparado,
    output logic                ocupado,
    output logic [ESTADO_W-1:0] estado
);

    localparam int AW = ancho_dir(PROF);
    localparam logic [AW-1:0] CARGA_PRE  = AW'(PROF - POST - 1);
    localparam logic [AW-1:0] CARGA_POST = AW'(POST - 1);

    estado_t          st_q;
    estado_t          st_d;
    logic [AW-1:0]    ptr_esc;
    logic [AW-1:0]    ptr_lec;
    logic [AW-1:0]    cnt;
    logic             disp_q;
    logic             ocup_q;
    logic             disparo;
    logic             escribe;
    logic             transfer;
    logic             ultimo;
    logic             lee;
    logic [AW-1:0]    dir_lec;
    logic [ANCHO-1:0] dato_mem;

    assign disparo  = ((sonda ^ patron) & mascara) == '0;
    assign escribe  = (st_q inside {ST_PRE, ST_ESPERA, ST_POST}) && !abortar;
    assign transfer = (st_q == ST_LECTURA) && lectura.dato_listo;
    // The write pointer is frozen during readout, so the newest sample sits just behind it.
    assign ultimo   = (st_q == ST_LECTURA) && (ptr_lec == (ptr_esc - AW'(1)));
    assign lee      = (st_q == ST_LISTO) || transfer;
    assign dir_lec  = (st_q == ST_LISTO) ? ptr_esc : (ptr_lec + AW'(1));

    always_comb begin
        st_d = st_q;
        if (abortar) begin
            st_d = ST_REPOSO;
        end else begin
            case (st_q)
                ST_REPOSO:  if (armar) st_d = (POST == PROF) ? ST_ESPERA : ST_PRE;
                ST_PRE:     if (cnt == '0) st_d = ST_ESPERA;
                ST_ESPERA:  if (disparo) st_d = (POST == 1) ? ST_LISTO : ST_POST;
                ST_POST:    if (cnt == AW'(1)) st_d = ST_LISTO;
                ST_LISTO:   st_d = ST_LECTURA;
                ST_LECTURA: if (transfer && ultimo) st_d = ST_REPOSO;
                default:    st_d = ST_REPOSO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_REPOSO;
            ptr_esc <= '0;
            ptr_lec <= '0;
            cnt     <= '0;
            disp_q  <= 1'b0;
            ocup_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            ocup_q <= st_d inside {ST_PRE, ST_ESPERA, ST_POST};
            if (escribe) begin
                ptr_esc <= ptr_esc + AW'(1);
            end
            if (!abortar) begin
                case (st_q)
                    ST_REPOSO: begin
                        if (armar) begin
                            cnt    <= CARGA_PRE;
                            disp_q <= 1'b0;
                        end
                    end
                    ST_PRE: cnt <= cnt - AW'(1);
                    ST_ESPERA: begin
                        if (disparo) begin
                            cnt    <= CARGA_POST;
                            disp_q <= 1'b1;
                        end
                    end
                    ST_POST:    cnt <= cnt - AW'(1);
                    ST_LISTO:   ptr_lec <= ptr_esc;
                    ST_LECTURA: if (transfer) ptr_lec <= ptr_lec + AW'(1);
                    default: ;
                endcase
            end
        end
    end

    sonda_mem #(
        .ANCHO (ANCHO),
        .PROF  (PROF),
        .AW    (AW)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .we       (escribe),
        .dir_esc  (ptr_esc),
        .dato_esc (sonda),
        .re       (lee),
        .dir_lec  (dir_lec),
        .dato_lec (dato_mem)
    );

    assign lectura.dato        = dato_mem;
    assign lectura.dato_valido = (st_q == ST_LECTURA);
    assign lectura.dato_ultimo = ultimo;
    assign disparado           = disp_q;
    assign ocupado             = ocup_q;
    assign estado              = st_q;

endmodule

// File: tb/tb_sonda_captura.sv
// Self-checking bench for sonda_captura: a sample-history model predicts every output,
// plus directed literal checks on the captured windows.
module tb_sonda_captura;

    localparam int ANCHO = 17;
    localparam int PROF  = 8;
    localparam int POST  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             armar;
    logic             abortar;
    logic             listo;
    logic [ANCHO-1:0] sonda;
    logic [ANCHO-1:0] patron;
    logic [ANCHO-1:0] mascara;
    logic             disparado;
    logic             ocupado;
    logic [2:0]       estado;

    int checks   = 0;
    int failures = 0;
    int cnt      = 0;
    int base;
    logic cmp_on = 1'b0;

    logic [ANCHO-1:0] recibidos [$];

    sonda_captura_if #(.ANCHO(ANCHO)) bus ();
    assign bus.dato_listo = listo;

    sonda_captura #(
        .ANCHO (ANCHO),
        .PROF  (PROF),
        .POST  (POST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sonda     (sonda),
        .patron    (patron),
        .mascara   (mascara),
        .armar     (armar),
        .abortar   (abortar),
        .lectura   (bus),
        .disparado (disparado),
        .ocupado   (ocupado),
        .estado    (estado)
    );

    always #5 clk = ~clk;

    // Probe value equals the running cycle number.
    initial begin
        sonda = '0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            sonda = ANCHO'(cnt);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic a_armar, input logic a_abortar, input logic a_rst, input logic a_listo);
        @(posedge clk);
        #2;
        armar   = a_armar;
        abortar = a_abortar;
        rst     = a_rst;
        listo   = a_listo;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic waitTransfers(input int n, input int budget);
        int k = 0;
        while (recibidos.size() < n && k < budget) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            k++;
        end
        checkOutput("espera_lectura", 32'(recibidos.size() >= n), 32'd1);
    endtask

    task automatic checkWindow(input string name, input int primero);
        checkOutput({name, "_tamano"}, 32'(recibidos.size()), 32'(PROF));
        for (int i = 0; i < recibidos.size() && i < PROF; i++) begin
            checkOutput(name, 32'(recibidos[i]), 32'(primero + i));
        end
    endtask

    // Model: phase code, remaining PRE/POST samples, and the history of written samples.
    int               m_phase = 0;
    int               m_pre   = 0;
    int               m_post  = 0;
    int               m_idx   = 0;
    logic             m_disp  = 1'b0;
    logic [ANCHO-1:0] m_hist [$];
    logic [ANCHO-1:0] m_win  [$];

    function automatic void guardar(input logic [ANCHO-1:0] v);
        m_hist.push_back(v);
        if (m_hist.size() > PROF) void'(m_hist.pop_front());
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_disp  = 1'b0;
            m_idx   = 0;
            m_hist.delete();
            m_win.delete();
        end else if (abortar) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (armar) begin
                    m_disp = 1'b0;
                    m_hist.delete();
                    if (POST == PROF) m_phase = 2;
                    else begin
                        m_pre   = PROF - POST;
                        m_phase = 1;
                    end
                end
                1: begin
                    guardar(sonda);
                    m_pre--;
                    if (m_pre == 0) m_phase = 2;
                end
                2: begin
                    guardar(sonda);
                    if ((sonda & mascara) == (patron & mascara)) begin
                        m_disp = 1'b1;
                        if (POST == 1) m_phase = 4;
                        else begin
                            m_post  = POST - 1;
                            m_phase = 3;
                        end
                    end
                end
                3: begin
                    guardar(sonda);
                    m_post--;
                    if (m_post == 0) m_phase = 4;
                end
                4: begin
                    m_win   = m_hist;
                    m_idx   = 0;
                    m_phase = 5;
                end
                5: if (listo) begin
                    m_idx++;
                    if (m_idx == PROF) m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
    end

    logic             prev_stall = 1'b0;
    logic [ANCHO-1:0] prev_dato  = '0;

    always @(negedge clk) begin
        if (cmp_on) begin
            checkOutput("estado", 32'(estado), 32'(m_phase));
            checkOutput("ocupado", 32'(ocupado), 32'(m_phase >= 1 && m_phase <= 3));
            checkOutput("disparado", 32'(disparado), 32'(m_disp));
            checkOutput("dato_valido", 32'(bus.dato_valido), 32'(m_phase == 5));
            checkOutput("dato_ultimo", 32'(bus.dato_ultimo), 32'(m_phase == 5 && m_idx == PROF - 1));
            if (m_phase == 5 && m_idx < m_win.size()) begin
                checkOutput("dato", 32'(bus.dato), 32'(m_win[m_idx]));
            end
            if (prev_stall) begin
                checkOutput("dato_estable", 32'(bus.dato), 32'(prev_dato));
            end
            prev_stall = bus.dato_valido && !listo;
            prev_dato  = bus.dato;
            if (bus.dato_valido && listo) recibidos.push_back(bus.dato);
        end
    end

    initial begin
        int k;
        rst     = 1'b1;
        armar   = 1'b0;
        abortar = 1'b0;
        listo   = 1'b0;
        patron  = '0;
        mascara = '1;

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        cmp_on = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        @(negedge clk);
        checkOutput("reset_dato", 32'(bus.dato), 32'd0);
        checkOutput("reset_estado", 32'(estado), 32'd0);

        // Full mask, pattern 20, arm at cycle 10: window 16..23.
        $display("[TB] masked trigger on value 20");
        patron = ANCHO'(20);
        k = 0;
        while (cnt != 9 && k < 100) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            k++;
        end
        checkOutput("inicio_t1", 32'(cnt), 32'd9);
        recibidos.delete();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        waitTransfers(PROF, 60);
        checkWindow("ventana_t1", 16);
        idleCycles(2);
        checkOutput("t1_disparado", 32'(disparado), 32'd1);

        // Empty mask: trigger on the first ESPERA cycle.
        $display("[TB] zero mask trigger");
        mascara = '0;
        recibidos.delete();
        base = cnt;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        waitTransfers(PROF, 60);
        checkWindow("ventana_t2", base + 2);
        idleCycles(2);

        // Pattern only present during PRE: must stay in ESPERA.
        $display("[TB] pattern seen only during PRE");
        mascara = '1;
        base = cnt;
        patron = ANCHO'(base + 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        idleCycles(20);
        @(negedge clk);
        checkOutput("t3_estado", 32'(estado), 32'd2);
        checkOutput("t3_ocupado", 32'(ocupado), 32'd1);
        checkOutput("t3_disparado", 32'(disparado), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t3_abortado", 32'(estado), 32'd0);

        // Readout with ready toggling 1,0,0.
        $display("[TB] stalled readout");
        mascara = '0;
        recibidos.delete();
        base = cnt;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        k = 0;
        while (recibidos.size() < PROF && k < 150) begin
            applyStimulus(1'b0, 1'b0, 1'b0, (k % 3) == 0);
            k++;
        end
        checkWindow("ventana_t4", base + 2);
        idleCycles(2);

        // Abort during POST, then a clean re-arm.
        $display("[TB] abort in POST then re-arm");
        mascara = '1;
        base = cnt;
        patron = ANCHO'(base + 6);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        idleCycles(6);
        @(negedge clk);
        checkOutput("t5_en_post", 32'(estado), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t5_abort_estado", 32'(estado), 32'd0);
        checkOutput("t5_abort_disparado", 32'(disparado), 32'd1);
        mascara = '0;
        recibidos.delete();
        base = cnt;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t5_rearm_disparado", 32'(disparado), 32'd0);
        checkOutput("t5_rearm_estado", 32'(estado), 32'd1);
        waitTransfers(PROF, 60);
        checkWindow("ventana_t5", base + 2);
        idleCycles(2);

        // Reset in the middle of readout.
        $display("[TB] reset during readout");
        recibidos.delete();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        waitTransfers(3, 60);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t6_estado", 32'(estado), 32'd0);
        checkOutput("t6_valido", 32'(bus.dato_valido), 32'd0);
        checkOutput("t6_disparado", 32'(disparado), 32'd0);
        idleCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
